// File: rtl/pc_branch_unit.sv
// PC / branch stage fed by the ALU's registered Cond flag; run control plus a saturating cycle counter.
// Optional BRANCH_REL_EN: LUT entries are PC-relative two's-complement offsets instead of absolute targets.
module pc_branch_unit #(
  parameter int PW       = 10,
  parameter int LW       = 5,
  parameter int CW       = 16,
  parameter int START_PC = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Cond,
  input  logic          BranchEn,
  input  logic          JumpEn,
  input  logic          Halt,
  input  logic [LW-1:0] BranchIdx,
  input  logic          LutWrEn,
  input  logic [LW-1:0] LutWrAddr,
  input  logic [PW-1:0] LutWrData,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PW-1:0] PC0 = PW'(START_PC);

  state_t        state;
  logic [PW-1:0] lut [0:2**LW-1];
  logic [PW-1:0] tgt;
  logic          taken;

`ifdef BRANCH_REL_EN
  assign tgt = PC + lut[BranchIdx];
`else
  assign tgt = lut[BranchIdx];
`endif

  // Jump and taken branch share one target, so jump priority only matters against Halt.
  assign taken   = JumpEn | (BranchEn & Cond);
  assign Running = (state == RUN);
  assign Done    = (state == DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= PC0;
      CycleCount <= '0;
      for (int i = 0; i < 2**LW; i++) lut[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          if (CycleCount != {CW{1'b1}}) CycleCount <= CycleCount + 1'b1;
          if (Halt)       state <= DONE;
          else if (taken) PC    <= tgt;
          else            PC    <= PC + 1'b1;
        end
        default: begin
          // LUT is writable only outside RUN, so a same-index read/write never collides.
          if (LutWrEn) lut[LutWrAddr] <= LutWrData;
          if (Start) begin
            state      <= RUN;
            PC         <= PC0;
            CycleCount <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a default instance and a CW=4 instance share all stimulus.
module tb_pc_branch_unit;

  logic       Clk = 0;
  logic       Reset, Start, Cond, BranchEn, JumpEn, Halt, LutWrEn;
  logic [4:0] BranchIdx, LutWrAddr;
  logic [9:0] LutWrData;
  logic [9:0] PC, PC4;
  logic       Running, Done, Running4, Done4;
  logic [15:0] CycleCount;
  logic [3:0]  CycleCount4;

  always #5 Clk = ~Clk;

  pc_branch_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Cond(Cond), .BranchEn(BranchEn),
    .JumpEn(JumpEn), .Halt(Halt), .BranchIdx(BranchIdx), .LutWrEn(LutWrEn),
    .LutWrAddr(LutWrAddr), .LutWrData(LutWrData), .PC(PC), .Running(Running),
    .Done(Done), .CycleCount(CycleCount));

  pc_branch_unit #(.CW(4)) dut_c4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Cond(Cond), .BranchEn(BranchEn),
    .JumpEn(JumpEn), .Halt(Halt), .BranchIdx(BranchIdx), .LutWrEn(LutWrEn),
    .LutWrAddr(LutWrAddr), .LutWrData(LutWrData), .PC(PC4), .Running(Running4),
    .Done(Done4), .CycleCount(CycleCount4));

  typedef struct {
    logic [9:0] pc;
    logic       run;
    logic       done;
    int         c16;
    int         c4;
  } exp_t;

  exp_t q[$];
  int nchk = 0, npass = 0;

  // reference model
  int         mst;   // 0 idle, 1 run, 2 done
  logic [9:0] mpc;
  int         mc16, mc4;
  logic [9:0] mlut [32];

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc = mpc; e.run = (mst == 1); e.done = (mst == 2); e.c16 = mc16; e.c4 = mc4;
    return e;
  endfunction

  task automatic model_reset();
    mst = 0; mpc = 10'h000; mc16 = 0; mc4 = 0;
    for (int i = 0; i < 32; i++) mlut[i] = 10'h000;
  endtask

  task automatic cmp_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({tag, "_pc"},   int'(PC),          int'(e.pc));
    chk({tag, "_pc4"},  int'(PC4),         int'(e.pc));
    chk({tag, "_run"},  int'(Running),     int'(e.run));
    chk({tag, "_done"}, int'(Done),        int'(e.done));
    chk({tag, "_cnt"},  int'(CycleCount),  e.c16);
    chk({tag, "_cnt4"}, int'(CycleCount4), e.c4);
  endtask

  // Drive one cycle of inputs, push the model's post-edge expectation, compare after the edge.
  task automatic step(input string tag, input logic st, hl, jp, br, cd,
                      input logic [4:0] idx, input logic we,
                      input logic [4:0] wa, input logic [9:0] wd);
    logic [9:0] tgt;
    Start = st; Halt = hl; JumpEn = jp; BranchEn = br; Cond = cd;
    BranchIdx = idx; LutWrEn = we; LutWrAddr = wa; LutWrData = wd;
`ifdef BRANCH_REL_EN
    tgt = mpc + mlut[idx];
`else
    tgt = mlut[idx];
`endif
    if (mst == 1) begin
      if (mc16 < 65535) mc16++;
      if (mc4 < 15) mc4++;
      if (hl) mst = 2;
      else if (jp || (br && cd)) mpc = tgt;
      else mpc = mpc + 10'd1;
    end else begin
      if (we) mlut[wa] = wd;
      if (st) begin mst = 1; mpc = 10'h000; mc16 = 0; mc4 = 0; end
    end
    q.push_back(snap());
    @(posedge Clk); #1;
    cmp_out(tag);
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
  endtask

  initial begin
    logic [9:0] lut2;
`ifdef BRANCH_REL_EN
    lut2 = 10'h3FE;
`else
    lut2 = 10'h1F0;
`endif
    Reset = 1; Start = 0; Cond = 0; BranchEn = 0; JumpEn = 0; Halt = 0;
    BranchIdx = 0; LutWrEn = 0; LutWrAddr = 0; LutWrData = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    q.push_back(snap());
    cmp_out("reset");
    Reset = 0;

    // LUT loads in IDLE
    step("lut_wr", 0, 0, 0, 0, 0, 5'd0, 1, 5'd2, lut2);
    step("lut_wr", 0, 0, 0, 0, 0, 5'd0, 1, 5'd3, 10'h155);
    step("lut_wr", 0, 0, 0, 0, 0, 5'd0, 1, 5'd7, 10'h0AA);

    // sequential run, halt at 5, frozen in DONE
    step("start", 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    idle_n("seq", 5);
    step("halt", 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    idle_n("frozen", 10);

    // restart from DONE, conditional branch not-taken then taken
    step("restart", 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    idle_n("seq2", 3);
    step("br_nt", 0, 0, 0, 1, 0, 5'd2, 0, 5'd0, 10'h0);
    step("br_t", 0, 0, 0, 1, 1, 5'd2, 0, 5'd0, 10'h0);
    step("start_ign", 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    // LUT write in RUN is ignored; jump must still see old entry
    step("wr_ign", 0, 0, 0, 0, 0, 5'd0, 1, 5'd7, 10'h123);
    step("jmp_old", 0, 0, 1, 0, 0, 5'd7, 0, 5'd0, 10'h0);
    step("jmp_br", 0, 0, 1, 1, 1, 5'd3, 0, 5'd0, 10'h0);
    step("prio", 0, 1, 1, 1, 1, 5'd3, 0, 5'd0, 10'h0);
    idle_n("frozen2", 2);

    // run to 0x015 and abort with async reset between edges
    step("start3", 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    idle_n("to15", 21);
    #2 Reset = 1;
    #1;
    model_reset();
    q.push_back(snap());
    cmp_out("rst_mid");
    @(posedge Clk); #1;
    Reset = 0;

    // LUT cleared by reset: jump via LUT[3]
    step("start4", 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    idle_n("pre_j", 2);
    step("jmp_clr", 0, 0, 1, 0, 0, 5'd3, 0, 5'd0, 10'h0);

    // long run: PC wraps 0x3FF->0, CW=4 counter saturates
    idle_n("wrap", 1030);
    step("halt_end", 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 10'h0);
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
